// File: rtl/mask_pkg.sv
// Shared types, derived constants and parameter legality for the M-ASK transmitter.
package mask_pkg;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   function automatic int num_levels(input int k);
      return 32'sd1 << k;
   endfunction

   function automatic int syms_per_word(input int data_w, input int k);
      return data_w / k;
   endfunction

   function automatic int clog2_min1(input int n);
      return (n > 32'sd1) ? $clog2(n) : 32'sd1;
   endfunction

   function automatic bit params_legal(input int data_w, input int k, input int sps,
                                       input int phase_w, input int sample_w);
      return (k >= 32'sd1) && (k <= 32'sd4) && (data_w >= k) && ((data_w % k) == 32'sd0) &&
             (sps >= 32'sd2) && (sps <= 32'sd4095) && (phase_w >= 32'sd2) && (sample_w >= 32'sd2);
   endfunction

endpackage

// File: rtl/mask_sine_rom.sv
// Full-period signed sine table built at elaboration, one-cycle registered read.
module mask_sine_rom #(
   parameter int PHASE_W  = 8,
   parameter int SAMPLE_W = 16
) (
   input  logic                       clk,
   input  logic [PHASE_W-1:0]         addr,
   output logic signed [SAMPLE_W-1:0] data
);
   localparam int  DEPTH = 32'sd1 << PHASE_W;
   localparam real PI    = 3.14159265358979323846;
   localparam real AMP   = real'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);

   logic signed [SAMPLE_W-1:0] rom_s [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_rom
      localparam real VAL = AMP * $sin(2.0 * PI * real'(i) / real'(DEPTH));
      // Round half away from zero so the table is symmetric about zero.
      localparam int  RND = (VAL >= 0.0) ? $rtoi(VAL + 0.5) : -$rtoi(0.5 - VAL);
      assign rom_s[i] = SAMPLE_W'(RND);
   end

   always_ff @(posedge clk) begin
      data <= rom_s[addr];
   end

endmodule

// File: rtl/mask_tx.sv
// M-ASK transmitter: each word leaves MSB-first as SPS-sample sine bursts whose
// amplitude is the symbol level; a one-word buffer allows gap-free streaming.
module mask_tx
   import mask_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int BITS_PER_SYM = 1,
   parameter int SPS          = 50,
   parameter int SAMPLE_W     = 16,
   parameter int PHASE_W      = 8,
   parameter int PHASE_INC    = 32
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       data_valid,
   output logic                       data_ready,
   output logic signed [SAMPLE_W-1:0] tx,
   output logic                       tx_valid,
   output logic                       sym_start,
   output logic                       busy
);
   localparam int K      = BITS_PER_SYM;
   localparam int M      = num_levels(K);
   localparam int SYMS   = syms_per_word(DATA_W, K);
   localparam int CNT_W  = clog2_min1(SPS);
   localparam int SYM_W  = clog2_min1(SYMS);
   localparam int PROD_W = SAMPLE_W + K + 1;
   localparam logic [CNT_W-1:0]         SPS_LAST = CNT_W'(SPS - 32'sd1);
   localparam logic [SYM_W-1:0]         SYM_LAST = SYM_W'(SYMS - 32'sd1);
   localparam logic signed [PROD_W-1:0] LVL_DIV  = PROD_W'(M - 32'sd1);
   localparam logic [PHASE_W-1:0]       PH_STEP  = PHASE_W'(PHASE_INC);

   if (!params_legal(DATA_W, BITS_PER_SYM, SPS, PHASE_W, SAMPLE_W)) begin : g_bad_params
      $error("mask_tx: illegal parameter combination");
   end

   state_e                     state_r, state_nx_s;
   logic [DATA_W-1:0]          shift_r, buf_r;
   logic                       buf_empty_r;
   logic [CNT_W-1:0]           sample_cnt_r;
   logic [SYM_W-1:0]           sym_cnt_r;
   logic [PHASE_W-1:0]         phase_r;
   logic                       accept_s, sym_end_s, last_s;
   logic                       load_in_s, load_buf_s, store_s;
   logic signed [SAMPLE_W-1:0] sine_r;
   logic [K-1:0]               lvl1_r;
   logic                       vld1_r, sst1_r;
   logic signed [SAMPLE_W-1:0] tx_r;
   logic                       tx_valid_r, sym_start_r;
   logic signed [PROD_W-1:0]   sine_ext_s, lvl_ext_s, prod_s;

   mask_sine_rom #(
      .PHASE_W  (PHASE_W),
      .SAMPLE_W (SAMPLE_W)
   ) u_rom (
      .clk  (sys_clk),
      .addr (phase_r),
      .data (sine_r)
   );

   // State register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_r <= ST_IDLE;
      else         state_r <= state_nx_s;
   end

   // Next state plus load/store steering; on the final sample a buffered word
   // wins, otherwise a word arriving that same cycle bypasses the buffer.
   always_comb begin
      state_nx_s = state_r;
      load_in_s  = 1'b0;
      load_buf_s = 1'b0;
      store_s    = 1'b0;
      accept_s   = data_valid & buf_empty_r;
      sym_end_s  = (state_r == ST_SEND) && (sample_cnt_r == SPS_LAST);
      last_s     = sym_end_s && (sym_cnt_r == SYM_LAST);
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nx_s = ST_SEND;
               load_in_s  = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (last_s && !buf_empty_r) load_buf_s = 1'b1;
            else if (last_s && accept_s) load_in_s = 1'b1;
            else if (last_s)             state_nx_s = ST_IDLE;
            else if (accept_s)           store_s = 1'b1;
            else                         store_s = 1'b0;
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Sine times level in a width that cannot overflow before the divide.
   always_comb begin
      sine_ext_s = {{(K + 1){sine_r[SAMPLE_W-1]}}, sine_r};
      lvl_ext_s  = {{(SAMPLE_W + 1){1'b0}}, lvl1_r};
      prod_s     = sine_ext_s * lvl_ext_s;
   end

   // Word sequencing, input buffer, carrier phase and the output pipeline.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         shift_r      <= {DATA_W{1'b0}};
         buf_r        <= {DATA_W{1'b0}};
         buf_empty_r  <= 1'b1;
         sample_cnt_r <= {CNT_W{1'b0}};
         sym_cnt_r    <= {SYM_W{1'b0}};
         phase_r      <= {PHASE_W{1'b0}};
         lvl1_r       <= {K{1'b0}};
         vld1_r       <= 1'b0;
         sst1_r       <= 1'b0;
         tx_r         <= {SAMPLE_W{1'b0}};
         tx_valid_r   <= 1'b0;
         sym_start_r  <= 1'b0;
      end else begin
         if (load_in_s)       shift_r <= data_in;
         else if (load_buf_s) shift_r <= buf_r;
         else if (sym_end_s)  shift_r <= shift_r << K;

         if (store_s) begin
            buf_r       <= data_in;
            buf_empty_r <= 1'b0;
         end else if (load_buf_s) begin
            buf_empty_r <= 1'b1;
         end

         if (state_r == ST_SEND) begin
            sample_cnt_r <= sym_end_s ? {CNT_W{1'b0}} : sample_cnt_r + CNT_W'(1'b1);
            if (last_s)         sym_cnt_r <= {SYM_W{1'b0}};
            else if (sym_end_s) sym_cnt_r <= sym_cnt_r + SYM_W'(1'b1);
            phase_r <= phase_r + PH_STEP;
         end else begin
            sample_cnt_r <= {CNT_W{1'b0}};
            sym_cnt_r    <= {SYM_W{1'b0}};
            phase_r      <= {PHASE_W{1'b0}};
         end

         vld1_r      <= (state_r == ST_SEND);
         lvl1_r      <= shift_r[DATA_W-1 -: K];
         sst1_r      <= (state_r == ST_SEND) && (sample_cnt_r == {CNT_W{1'b0}});
         tx_r        <= vld1_r ? SAMPLE_W'(prod_s / LVL_DIV) : {SAMPLE_W{1'b0}};
         tx_valid_r  <= vld1_r;
         sym_start_r <= sst1_r;
      end
   end

   assign data_ready = buf_empty_r;
   assign tx         = tx_r;
   assign tx_valid   = tx_valid_r;
   assign sym_start  = sym_start_r;
   assign busy       = (state_r == ST_SEND);

endmodule

// File: tb/tb_mask_tx.sv
// Scoreboard bench for mask_tx: binary ASK (defaults) and 4-ASK (k=2, 8-bit words).
module tb_mask_tx;
   typedef struct { int tx; int ss; } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic [15:0] d1;
   logic v1, r1, tv1, ss1, b1;
   logic signed [15:0] tx1;
   logic [7:0] d2;
   logic v2, r2, tv2, ss2, b2;
   logic signed [15:0] tx2;

   int n_vec = 0, n_err = 0, cyc = 0;
   exp_t q1[$], q2[$];
   int ph1 = 0, ph2 = 0;
   int run1 = 0, run2 = 0, low1 = 0, rise1 = -1, sym2 = -1;
   int runs1[$], runs2[$], lows1[$];
   int peak2[4] = '{default: 0};

   mask_tx #(.DATA_W(16), .BITS_PER_SYM(1), .SPS(50), .SAMPLE_W(16), .PHASE_W(8), .PHASE_INC(32)) u_dut1 (
      .sys_clk(clk), .sys_rst(rst), .data_in(d1), .data_valid(v1), .data_ready(r1),
      .tx(tx1), .tx_valid(tv1), .sym_start(ss1), .busy(b1));

   mask_tx #(.DATA_W(8), .BITS_PER_SYM(2), .SPS(50), .SAMPLE_W(16), .PHASE_W(8), .PHASE_INC(32)) u_dut2 (
      .sys_clk(clk), .sys_rst(rst), .data_in(d2), .data_valid(v2), .data_ready(r2),
      .tx(tx2), .tx_valid(tv2), .sym_start(ss2), .busy(b2));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int sine_model(input int p);
      real v;
      v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(p) / 256.0);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
   endfunction

   // Expected samples of one word; cont=1 continues the carrier phase of the previous word.
   task automatic push_word(input int dut, input logic [15:0] w, input bit cont);
      int k, dw, m1, lvl, ph;
      exp_t e;
      k  = (dut == 1) ? 1 : 2;
      dw = (dut == 1) ? 16 : 8;
      m1 = (1 << k) - 1;
      ph = (dut == 1) ? ph1 : ph2;
      if (!cont) ph = 0;
      for (int s = 0; s < dw / k; s++) begin
         lvl = int'((w >> (dw - k * (s + 1))) & ((16'd1 << k) - 16'd1));
         for (int n = 0; n < 50; n++) begin
            e.tx = sine_model(ph) * lvl / m1;
            e.ss = (n == 0) ? 1 : 0;
            if (dut == 1) q1.push_back(e);
            else          q2.push_back(e);
            ph = (ph + 32) % 256;
         end
      end
      if (dut == 1) ph1 = ph;
      else          ph2 = ph;
   endtask

   task automatic offer(input int dut, input logic [15:0] w, input bit cont, input bit hold, output int acc);
      bit done = 1'b0;
      acc = -1;
      if (dut == 1) begin d1 = w; v1 = 1'b1; end
      else begin d2 = w[7:0]; v2 = 1'b1; end
      for (int i = 0; i < 3000 && !done; i++) begin
         if ((dut == 1 && r1) || (dut == 2 && r2)) begin
            push_word(dut, w, cont);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (done) acc = cyc;
      else begin
         n_vec++; n_err++;
         $display("FAIL offer_timeout dut%0d: word %h not accepted, required acceptance", dut, w);
      end
      if (!hold) begin
         if (dut == 1) v1 = 1'b0;
         else          v2 = 1'b0;
      end
   endtask

   task automatic wait_idle(input int dut);
      bit done = 1'b0;
      for (int i = 0; i < 5000 && !done; i++) begin
         @(negedge clk);
         if (dut == 1) done = (q1.size() == 0) && !tv1 && !b1;
         else          done = (q2.size() == 0) && !tv2 && !b2;
      end
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL idle_timeout dut%0d: still busy, required idle", dut);
      end
      @(posedge clk); #1;
   endtask

   initial begin : mon1
      exp_t e;
      bit prev;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (tv1) begin
            if (!prev) rise1 = cyc;
            run1++;
            if (q1.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL sample1_unexpected: got tx %0d, expected no sample", tx1);
            end else begin
               e = q1.pop_front();
               check("tx1", int'(tx1), e.tx);
               check("sym_start1", int'(ss1), e.ss);
            end
         end else begin
            check("tx1_idle_zero", int'(tx1), 0);
            if (run1 != 0) begin runs1.push_back(run1); run1 = 0; end
         end
         if (!r1) low1++;
         else if (low1 != 0) begin lows1.push_back(low1); low1 = 0; end
         prev = tv1;
      end
   end

   initial begin : mon2
      exp_t e;
      int a;
      forever begin
         @(negedge clk);
         if (tv2) begin
            run2++;
            if (ss2) sym2++;
            a = (tx2 < 0) ? -int'(tx2) : int'(tx2);
            if (sym2 >= 0 && sym2 < 4 && a > peak2[sym2]) peak2[sym2] = a;
            if (q2.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL sample2_unexpected: got tx %0d, expected no sample", tx2);
            end else begin
               e = q2.pop_front();
               check("tx2", int'(tx2), e.tx);
               check("sym_start2", int'(ss2), e.ss);
            end
         end else begin
            check("tx2_idle_zero", int'(tx2), 0);
            if (run2 != 0) begin runs2.push_back(run2); run2 = 0; end
         end
      end
   end

   initial begin : stim
      int a0, a1, a2;
      rst = 1'b1; d1 = 16'h0000; v1 = 1'b0; d2 = 8'h00; v2 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_tx", int'(tx1), 0);
      check("rst_tx_valid", int'(tv1), 0);
      check("rst_sym_start", int'(ss1), 0);
      check("rst_busy", int'(b1), 0);
      check("rst_data_ready", int'(r1), 1);
      check("rst_data_ready2", int'(r2), 1);
      @(posedge clk); #1;

      // Single word: latency and burst length.
      offer(1, 16'hFEC8, 1'b0, 1'b0, a0);
      wait_idle(1);
      check("first_valid_latency", rise1 - a0, 2);
      if (runs1.size() == 1) check("single_word_run", runs1.pop_front(), 800);
      else check("single_word_run_count", runs1.size(), 1);

      // Three words with data_valid held high.
      runs1.delete(); lows1.delete();
      offer(1, 16'hFEC8, 1'b0, 1'b1, a0);
      offer(1, 16'h0137, 1'b1, 1'b1, a1);
      offer(1, 16'hF0F0, 1'b1, 1'b0, a2);
      wait_idle(1);
      check("second_accept_delay", a1 - a0, 1);
      check("third_accept_delay", a2 - a0, 801);
      if (runs1.size() == 1) check("three_word_run", runs1.pop_front(), 2400);
      else check("three_word_run_count", runs1.size(), 1);
      if (lows1.size() == 2) begin
         check("ready_low_1", lows1.pop_front(), 799);
         check("ready_low_2", lows1.pop_front(), 799);
      end else check("ready_low_count", lows1.size(), 2);

      // Word offered exactly on the last sample cycle of the current word.
      runs1.delete(); lows1.delete();
      offer(1, 16'hA5C3, 1'b0, 1'b0, a0);
      repeat (799) @(posedge clk);
      #1;
      offer(1, 16'h0137, 1'b1, 1'b0, a1);
      check("last_cycle_accept", a1 - a0, 800);
      wait_idle(1);
      if (runs1.size() == 1) check("last_cycle_run", runs1.pop_front(), 1600);
      else check("last_cycle_run_count", runs1.size(), 1);
      check("last_cycle_no_ready_low", lows1.size(), 0);

      // Reset at cycle 300 of a word with the buffer full.
      runs1.delete(); lows1.delete();
      offer(1, 16'hFEC8, 1'b0, 1'b0, a0);
      offer(1, 16'h0F0F, 1'b1, 1'b0, a1);
      repeat (298) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      q1.delete();
      @(negedge clk);
      check("midrst_tx", int'(tx1), 0);
      check("midrst_tx_valid", int'(tv1), 0);
      check("midrst_sym_start", int'(ss1), 0);
      check("midrst_busy", int'(b1), 0);
      check("midrst_data_ready", int'(r1), 1);
      repeat (5) @(posedge clk);
      #1;
      offer(1, 16'hC0DE, 1'b0, 1'b0, a0);
      wait_idle(1);
      if (runs1.size() == 2) begin
         check("midrst_partial_run", runs1.pop_front(), 298);
         check("post_rst_run", runs1.pop_front(), 800);
      end else check("midrst_run_count", runs1.size(), 2);
      if (lows1.size() == 1) check("midrst_ready_low", lows1.pop_front(), 299);
      else check("midrst_ready_low_count", lows1.size(), 1);

      // 4-ASK: levels 0,1,2,3.
      offer(2, 16'h001B, 1'b0, 1'b0, a0);
      wait_idle(2);
      if (runs2.size() == 1) check("ask4_run", runs2.pop_front(), 200);
      else check("ask4_run_count", runs2.size(), 1);
      check("ask4_sym_count", sym2 + 1, 4);
      check("ask4_peak_L0", peak2[0], 0);
      check("ask4_peak_L1", peak2[1], 10922);
      check("ask4_peak_L2", peak2[2], 21844);
      check("ask4_peak_L3", peak2[3], 32767);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mask_tx.md
MASK_TX -- requirements
Module: mask_tx

Interface
REQ-001 Parameter DATA_W, 16, width of one input word.
REQ-002 Parameter BITS_PER_SYM, 1, bits per symbol k; M = 2^k amplitude levels; legal 1..4; DATA_W divisible by k.
REQ-003 Parameter SPS, 50, clock cycles (samples) per symbol; legal 2..4095.
REQ-004 Parameter SAMPLE_W, 16, signed output sample width.
REQ-005 Parameter PHASE_W, 8, carrier phase accumulator width; ROM depth 2^PHASE_W.
REQ-006 Parameter PHASE_INC, 32, phase step per clock.
REQ-007 sys_clk  in  1  single clock; all logic on rising edge.
REQ-008 sys_rst  in  1  synchronous, active-high reset.
REQ-009 data_in  in  DATA_W  word to transmit, MSB-first.
REQ-010 data_valid  in  1  data_in valid; accepted on cycle with data_valid & data_ready.
REQ-011 data_ready  out  1  high when the one-word buffer is empty.
REQ-012 tx  out  SAMPLE_W  signed modulated sample.
REQ-013 tx_valid  out  1  tx carries a live sample.
REQ-014 sym_start  out  1  one-cycle strobe aligned with the first tx sample of each symbol.
REQ-015 busy  out  1  high in state SEND.

Function
REQ-016 FSM states IDLE, SEND; IDLE->SEND when a word is accepted; SEND->IDLE after the last sample of the last symbol with buffer empty and no word accepted in that cycle.
REQ-017 Word = DATA_W/k symbols, each k bits taken MSB-first; symbol value = level L in 0..M-1 (plain binary).
REQ-018 Sample counter runs 0..SPS-1 per symbol; symbol counter 0..DATA_W/k-1 per word; both wrap to 0.
REQ-019 One-word buffer: accepted word in SEND held until current word ends, then loaded into shift register with no idle gap.
REQ-020 Accept in IDLE, or in SEND's last cycle with buffer empty, loads the shift register directly (bypass), zero gap.
REQ-021 data_ready = buffer empty; data_ready is high in IDLE.
REQ-022 Phase accumulator cleared to 0 on IDLE->SEND; advances by PHASE_INC modulo 2^PHASE_W each SEND cycle; continuous across back-to-back words.
REQ-023 Sine ROM: signed SAMPLE_W entries, round((2^(SAMPLE_W-1)-1)*sin(2*pi*i/2^PHASE_W)); registered read, 1 cycle.
REQ-024 tx = trunc_toward_zero(sine*L/(M-1)); product width SAMPLE_W+k+1; no overflow possible; registered, 1 cycle.
REQ-025 Latency: first tx_valid sample 2 cycles after the accepting edge; tx_valid falls 2 cycles after the SEND->IDLE edge.
REQ-026 tx = 0 whenever tx_valid = 0.
REQ-027 sym_start delayed through the same 2-stage pipeline as tx.
REQ-028 data_valid with data_ready low: word ignored; data_in need not be held.

Reset
REQ-029 On sys_rst at a clock edge: state IDLE, counters/phase 0, buffer empty, pipeline cleared; tx=0, tx_valid=0, sym_start=0, busy=0, data_ready=1 after that edge.
REQ-030 Reset mid-word aborts transmission; current and buffered words discarded; no sample emitted from pre-reset data.

Structure
REQ-031 Shared package mask_pkg holds state enum, M and symbols-per-word derivations, and parameter legality checks.
REQ-032 Sine ROM is sub-module mask_sine_rom (PHASE_W, SAMPLE_W), contents generated at elaboration.
REQ-033 Top RTL 120-400 lines; no clock gating, no second clock.

Verification
REQ-034 Defaults, accept 0xFEC8 once: tx_valid exactly 800 cycles from edge 2; symbols 1,1,1,1,1,1,1,0,1,1,0,0,1,0,0,0; zero-symbol samples all 0.
REQ-035 BITS_PER_SYM=2, DATA_W=8, word 0x1B: 4 symbols L=0,1,2,3; peak |tx| = 0, ~10922, ~21844, 32767 respectively.
REQ-036 Three words 0xFEC8, 0x0137, 0xF0F0 offered continuously: 2400 contiguous tx_valid cycles, no gap, sym_start every 50 cycles, phase continuous at word boundaries.
REQ-037 data_valid held high constantly: data_ready low 1..799 cycles after each load; no word lost or duplicated (scoreboard).
REQ-038 sys_rst pulse at cycle 300 of a word with buffer full: all outputs at reset values next cycle; next accepted word starts at phase 0.
REQ-039 Word offered exactly on last sample cycle with buffer empty: accepted same cycle, zero-gap continuation.
